// File: rtl/aibcr3aux_actred_pkg.sv
// Shared types and helpers for the active-redundancy receive chain.
// Holds the deframer state encoding, error cause codes and the thermometer decode.
package aibcr3aux_actred_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_FRAME  = 2'd1;
  localparam logic [1:0] ERR_PARITY = 2'd2;
  localparam logic [1:0] ERR_RANGE  = 2'd3;

  // Lanes at or above the failing index shift over; index==NLANES means no repair.
  function automatic logic therm_bit(input int lane, input int idx);
    return (lane >= idx);
  endfunction

endpackage

// File: rtl/aibcr3aux_actred_rx_sync.sv
// Two-flop synchronizer for the asynchronous redundancy line; resets to the idle-high level.
// Latency: 2 clk from input to output.
module aibcr3aux_actred_rx_sync (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/aibcr3aux_actred_rx.sv
// Active-redundancy receive: sync, deframe, check and thermometer-decode the repair index.
// Build with AIBCR3AUX_ACTRED_RX_DBLCHK_EN to commit only after two matching good frames.
module aibcr3aux_actred_rx
  import aibcr3aux_actred_pkg::*;
#(
  parameter int NLANES = 16,
  parameter int IDXW   = 5,
  parameter int OSR    = 8
) (
  input  logic              osc_clk,
  input  logic              dig_rstb,
  input  logic              actred_rx_in,
  input  logic              csr_actred_rxen,
  input  logic              csr_actred_errclr,
  output logic [NLANES-1:0] shiften_out,
  output logic              actred_upd,
  output logic              actred_err,
  output logic              actred_busy
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BW = (IDXW > 1) ? $clog2(IDXW) : 1;
  localparam logic [CW-1:0] CNT_MID = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OSR - 1);

  rx_state_e         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bitidx, bitidx_nxt;
  logic [IDXW-1:0]   shreg;
  logic [IDXW-1:0]   idx_q;
  logic              par_q;
  logic              rxs, rxs_d;
  logic              smp_data, smp_par, eval;
  logic [1:0]        cause;
  logic              frame_good, commit, commit_q;
  logic [NLANES-1:0] thm;

  aibcr3aux_actred_rx_sync u_sync (
    .clk  (osc_clk),
    .rstb (dig_rstb),
    .din  (actred_rx_in),
    .dout (rxs)
  );

  // After the start-bit mid-sample the counter is re-zeroed, so later mid-bits land on CNT_END.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    bitidx_nxt = bitidx;
    smp_data   = 1'b0;
    smp_par    = 1'b0;
    eval       = 1'b0;
    if (!csr_actred_rxen) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (rxs_d && !rxs) state_nxt = START;
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt_nxt    = '0;
            bitidx_nxt = '0;
            state_nxt  = rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            cnt_nxt  = '0;
            smp_data = 1'b1;
            if (bitidx == BW'(IDXW - 1)) state_nxt = PARITY;
            else                         bitidx_nxt = bitidx + BW'(1);
          end
        end
        PARITY: begin
          if (cnt == CNT_END) begin
            cnt_nxt   = '0;
            smp_par   = 1'b1;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (cnt == CNT_END) begin
            cnt_nxt   = '0;
            eval      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Cause is only meaningful in the eval cycle, where rxs is the stop bit.
  always_comb begin
    cause = ERR_NONE;
    if (!rxs)                         cause = ERR_FRAME;
    else if ((^shreg) != par_q)       cause = ERR_PARITY;
    else if (shreg > IDXW'(NLANES))   cause = ERR_RANGE;
  end

  assign frame_good = eval && (cause == ERR_NONE);

`ifdef AIBCR3AUX_ACTRED_RX_DBLCHK_EN
  logic            stage_vld;
  logic [IDXW-1:0] stage_idx;

  assign commit = frame_good && stage_vld && (stage_idx == shreg);

  always_ff @(posedge osc_clk) begin
    if (!dig_rstb) begin
      stage_vld <= 1'b0;
      stage_idx <= '0;
    end else if (eval) begin
      stage_vld <= frame_good;
      if (frame_good) stage_idx <= shreg;
    end
  end
`else
  assign commit = frame_good;
`endif

  always_comb begin
    thm = '0;
    for (int i = 0; i < NLANES; i++) thm[i] = therm_bit(i, int'(idx_q));
  end

  always_ff @(posedge osc_clk) begin
    if (!dig_rstb) begin
      state       <= IDLE;
      cnt         <= '0;
      bitidx      <= '0;
      shreg       <= '0;
      par_q       <= 1'b0;
      rxs_d       <= 1'b1;
      idx_q       <= '0;
      commit_q    <= 1'b0;
      shiften_out <= '0;
      actred_upd  <= 1'b0;
      actred_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bitidx     <= bitidx_nxt;
      rxs_d      <= rxs;
      commit_q   <= commit;
      actred_upd <= commit_q;
      if (smp_data) shreg[bitidx] <= rxs;
      if (smp_par)  par_q <= rxs;
      if (commit)   idx_q <= shreg;
      if (commit_q) shiften_out <= thm;
      // A new error outranks a concurrent clear.
      if (eval && (cause != ERR_NONE)) actred_err <= 1'b1;
      else if (csr_actred_errclr)      actred_err <= 1'b0;
    end
  end

  assign actred_busy = (state != IDLE);

endmodule

// File: tb/tb_aibcr3aux_actred_rx.sv
// Scoreboard bench for aibcr3aux_actred_rx: directed frames push expected events, a monitor checks them.
module tb_aibcr3aux_actred_rx;

  localparam int OSR = 8;

  logic        osc_clk = 1'b0;
  logic        dig_rstb;
  logic        actred_rx_in;
  logic        csr_actred_rxen;
  logic        csr_actred_errclr;
  logic [15:0] shiften_out;
  logic        actred_upd;
  logic        actred_err;
  logic        actred_busy;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    int          lo;
    int          hi;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic        err_prev = 1'b0;
  logic [15:0] m_shift = 16'h0000;
  bit          stv = 1'b0;
  int          sti = 0;

  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) cyc <= cyc + 1;

  aibcr3aux_actred_rx #(.NLANES(16), .IDXW(5), .OSR(OSR)) dut (
    .osc_clk           (osc_clk),
    .dig_rstb          (dig_rstb),
    .actred_rx_in      (actred_rx_in),
    .csr_actred_rxen   (csr_actred_rxen),
    .csr_actred_errclr (csr_actred_errclr),
    .shiften_out       (shiften_out),
    .actred_upd        (actred_upd),
    .actred_err        (actred_err),
    .actred_busy       (actred_busy)
  );

  // Monitor: every update pulse or error rising edge must match the head of the queue.
  always @(negedge osc_clk) begin
    if (mon_en && (actred_upd || (actred_err && !err_prev))) begin
      ncmp++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_event: upd=%b err=%b shiften=%h cycle=%0d",
                 actred_upd, actred_err, shiften_out, cyc);
      end else begin
        me = q.pop_front();
        if ((me.is_err == actred_upd) || (shiften_out !== me.val) ||
            (cyc < me.lo) || (cyc > me.hi)) begin
          nfail++;
          $display("FAIL event: got %s shiften=%h cycle=%0d, want %s shiften=%h cycle %0d..%0d",
                   actred_upd ? "upd" : "err", shiften_out, cyc,
                   me.is_err ? "err" : "upd", me.val, me.lo, me.hi);
        end
      end
    end
    err_prev = actred_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  task automatic realign();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic push_evt(input bit is_err, input logic [15:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    e.lo     = cyc + 56;
    e.hi     = cyc + 72;
    q.push_back(e);
  endtask

  // Caller is positioned just after a rising edge. upd_val is the hand-computed thermometer.
  task automatic send_frame(input int idx, input bit flip, input bit stopv,
                            input bit track, input logic [15:0] upd_val);
    logic [4:0] d;
    logic [7:0] f;
    d = idx[4:0];
    f = {stopv, (^d) ^ flip, d, 1'b0};
    if (track) begin
      if (!stopv || flip || idx > 16) begin
        push_evt(1'b1, m_shift);
        stv = 1'b0;
      end else begin
`ifdef AIBCR3AUX_ACTRED_RX_DBLCHK_EN
        if (stv && sti == idx) begin
          push_evt(1'b0, upd_val);
          m_shift = upd_val;
        end
        stv = 1'b1;
        sti = idx;
`else
        push_evt(1'b0, upd_val);
        m_shift = upd_val;
`endif
      end
    end
    for (int k = 0; k < 8; k++) begin
      actred_rx_in = f[k];
      idle(OSR);
    end
    actred_rx_in = 1'b1;
  endtask

  task automatic send_good(input int idx, input logic [15:0] upd_val);
`ifdef AIBCR3AUX_ACTRED_RX_DBLCHK_EN
    send_frame(idx, 1'b0, 1'b1, 1'b1, upd_val);
`endif
    send_frame(idx, 1'b0, 1'b1, 1'b1, upd_val);
    idle(16);
  endtask

  task automatic clear_err();
    csr_actred_errclr = 1'b1;
    idle(2);
    csr_actred_errclr = 1'b0;
    @(negedge osc_clk);
    chk("err_cleared", 32'(actred_err), 32'd0);
    realign();
  endtask

  initial begin
    dig_rstb          = 1'b0;
    actred_rx_in      = 1'b1;
    csr_actred_rxen   = 1'b1;
    csr_actred_errclr = 1'b0;
    idle(5);
    @(negedge osc_clk);
    chk("rst_shiften", 32'(shiften_out), 32'h0000);
    chk("rst_err", 32'(actred_err), 32'd0);
    chk("rst_busy", 32'(actred_busy), 32'd0);
    chk("rst_upd", 32'(actred_upd), 32'd0);
    realign();
    dig_rstb = 1'b1;
    mon_en   = 1'b1;

    // Idle line: nothing may happen.
    idle(200);
    @(negedge osc_clk);
    chk("idle_shiften", 32'(shiften_out), 32'h0000);
    chk("idle_err", 32'(actred_err), 32'd0);
    chk("idle_busy", 32'(actred_busy), 32'd0);
    realign();

    send_good(5, 16'hFFE0);
    @(negedge osc_clk);
    chk("idx5_shiften", 32'(shiften_out), 32'hFFE0);
    realign();

    // Parity error.
    send_frame(3, 1'b1, 1'b1, 1'b1, 16'h0000);
    idle(16);
    @(negedge osc_clk);
    chk("par_err", 32'(actred_err), 32'd1);
    chk("par_hold", 32'(shiften_out), 32'hFFE0);
    realign();
    clear_err();

    // Range error.
    send_frame(17, 1'b0, 1'b1, 1'b1, 16'h0000);
    idle(16);
    @(negedge osc_clk);
    chk("range_err", 32'(actred_err), 32'd1);
    chk("range_hold", 32'(shiften_out), 32'hFFE0);
    realign();
    clear_err();

    // Framing error.
    send_frame(9, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(16);
    @(negedge osc_clk);
    chk("frame_err", 32'(actred_err), 32'd1);
    realign();
    clear_err();

    send_good(16, 16'h0000);
    @(negedge osc_clk);
    chk("idx16_shiften", 32'(shiften_out), 32'h0000);
    realign();

    send_good(0, 16'hFFFF);
    @(negedge osc_clk);
    chk("idx0_shiften", 32'(shiften_out), 32'hFFFF);
    realign();

    // Short low glitch: START then back to IDLE without error.
    actred_rx_in = 1'b0;
    idle(3);
    actred_rx_in = 1'b1;
    @(negedge osc_clk);
    chk("glitch_busy", 32'(actred_busy), 32'd1);
    realign();
    idle(20);
    @(negedge osc_clk);
    chk("glitch_idle", 32'(actred_busy), 32'd0);
    chk("glitch_noerr", 32'(actred_err), 32'd0);
    realign();

    // Receive enable dropped mid-frame.
    fork
      send_frame(6, 1'b0, 1'b1, 1'b0, 16'h0000);
    join_none
    idle(24);
    @(negedge osc_clk);
    chk("rxen_busy_data", 32'(actred_busy), 32'd1);
    realign();
    csr_actred_rxen = 1'b0;
    @(posedge osc_clk);
    @(negedge osc_clk);
    chk("rxen_busy_drop", 32'(actred_busy), 32'd0);
    chk("rxen_hold", 32'(shiften_out), 32'hFFFF);
    realign();
    idle(50);
    csr_actred_rxen = 1'b1;
    idle(16);

    send_frame(2, 1'b0, 1'b1, 1'b1, 16'hFFFC);
    idle(8);
    send_frame(4, 1'b0, 1'b1, 1'b1, 16'hFFF0);
    idle(8);
    send_frame(4, 1'b0, 1'b1, 1'b1, 16'hFFF0);
    idle(16);
    @(negedge osc_clk);
    chk("idx4_shiften", 32'(shiften_out), 32'hFFF0);
    realign();

    // Reset mid-frame (all-ones payload so the tail cannot look like a new start).
    fork
      send_frame(31, 1'b0, 1'b1, 1'b0, 16'h0000);
    join_none
    idle(30);
    dig_rstb = 1'b0;
    @(posedge osc_clk);
    @(negedge osc_clk);
    chk("midrst_shiften", 32'(shiften_out), 32'h0000);
    chk("midrst_busy", 32'(actred_busy), 32'd0);
    chk("midrst_err", 32'(actred_err), 32'd0);
    realign();
    dig_rstb = 1'b1;
    m_shift  = 16'h0000;
    stv      = 1'b0;
    idle(50);
    @(negedge osc_clk);
    chk("postrst_shiften", 32'(shiften_out), 32'h0000);
    realign();

    // Back-to-back frames, no idle gap.
    send_frame(8, 1'b0, 1'b1, 1'b1, 16'hFF00);
    send_frame(8, 1'b0, 1'b1, 1'b1, 16'hFF00);
    idle(16);
    @(negedge osc_clk);
    chk("b2b_shiften", 32'(shiften_out), 32'hFF00);
    chk("b2b_noerr", 32'(actred_err), 32'd0);
    realign();

    idle(100);
    while (q.size() > 0) begin
      me = q.pop_front();
      ncmp++;
      nfail++;
      $display("FAIL missing_event: want %s shiften=%h by cycle %0d",
               me.is_err ? "err" : "upd", me.val, me.hi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
